// File: rtl/pulse_mo1001oh.sv
// Moore detector for the serial marker 1-0-0-1 with overlap, one-hot state.
// out is bit 4 of the state register, so it has no combinational path from in.
module pulse_mo1001oh (
   input  logic       clk,
   input  logic       rst,
   input  logic       in,
   output logic       out,
   output logic [4:0] state_oh
);

   localparam int unsigned STATE_W = 5;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 5'b00001,
      S1    = 5'b00010,
      S10   = 5'b00100,
      S100  = 5'b01000,
      S1001 = 5'b10000
   } state_t;

   state_t state;
   state_t state_nx;

   // Next-state logic; any code that is not exactly one-hot falls back to IDLE.
   always_comb begin
      state_nx = IDLE;
      case (state)
         IDLE:    state_nx = in ? S1    : IDLE;
         S1:      state_nx = in ? S1    : S10;
         S10:     state_nx = in ? S1    : S100;
         S100:    state_nx = in ? S1001 : IDLE;
         S1001:   state_nx = in ? S1    : S10;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   assign state_oh = STATE_W'(state);
   assign out      = state_oh[4];

endmodule

// File: tb/tb_pulse_mo1001oh.sv
// Scoreboard bench for pulse_mo1001oh: the driver queues the hand-computed
// state/out expected after each edge; the monitor pops and compares.
module tb_pulse_mo1001oh;

   logic       clk;
   logic       rst;
   logic       in;
   logic       out;
   logic [4:0] state_oh;

   typedef struct {
      logic [4:0] state;
      logic       out;
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   pulse_mo1001oh dut (
      .clk      (clk),
      .rst      (rst),
      .in       (in),
      .out      (out),
      .state_oh (state_oh)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One tracked edge: drive on the falling edge, expect the result after the next rise.
   task automatic step(input logic r, input logic b, input logic [4:0] es,
                       input logic eo, input string tag);
      exp_t e;
      @(negedge clk);
      rst = r;
      in  = b;
      e.state = es;
      e.out   = eo;
      e.tag   = tag;
      exp_q.push_back(e);
   endtask

   // Monitor: every rising edge with an outstanding expectation is checked 1 time unit later.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (state_oh !== e.state) begin
               failures++;
               $display("FAIL %s state_oh: got %b expected %b", e.tag, state_oh, e.state);
            end
            checks++;
            if (out !== e.out) begin
               failures++;
               $display("FAIL %s out: got %b expected %b", e.tag, out, e.out);
            end
         end
      end
   end

   initial begin
      int wait_cycles;
      rst = 1'b1;
      in  = 1'b0;
      repeat (2) @(posedge clk);

      // 1: 1,0,1,1,0,0,1 then a 0 to show the pulse lasts one cycle
      step(1, 0, 5'b00001, 0, "t1_reset");
      step(0, 1, 5'b00010, 0, "t1_b1");
      step(0, 0, 5'b00100, 0, "t1_b2");
      step(0, 1, 5'b00010, 0, "t1_b3");
      step(0, 1, 5'b00010, 0, "t1_b4");
      step(0, 0, 5'b00100, 0, "t1_b5");
      step(0, 0, 5'b01000, 0, "t1_b6");
      step(0, 1, 5'b10000, 1, "t1_b7_detect");
      step(0, 0, 5'b00100, 0, "t1_after");

      // 2: overlap 1,0,0,1,0,0,1 then 1
      step(1, 1, 5'b00001, 0, "t2_reset");
      step(0, 1, 5'b00010, 0, "t2_b1");
      step(0, 0, 5'b00100, 0, "t2_b2");
      step(0, 0, 5'b01000, 0, "t2_b3");
      step(0, 1, 5'b10000, 1, "t2_b4_detect");
      step(0, 0, 5'b00100, 0, "t2_b5_overlap");
      step(0, 0, 5'b01000, 0, "t2_b6");
      step(0, 1, 5'b10000, 1, "t2_b7_detect");
      step(0, 1, 5'b00010, 0, "t2_exit_s1");

      // 3a: near-miss 1,0,0,0,1
      step(1, 0, 5'b00001, 0, "t3a_reset");
      step(0, 1, 5'b00010, 0, "t3a_b1");
      step(0, 0, 5'b00100, 0, "t3a_b2");
      step(0, 0, 5'b01000, 0, "t3a_b3");
      step(0, 0, 5'b00001, 0, "t3a_b4_idle");
      step(0, 1, 5'b00010, 0, "t3a_b5");

      // 3b: near-miss 1,1,0,1
      step(1, 0, 5'b00001, 0, "t3b_reset");
      step(0, 1, 5'b00010, 0, "t3b_b1");
      step(0, 1, 5'b00010, 0, "t3b_b2");
      step(0, 0, 5'b00100, 0, "t3b_b3");
      step(0, 1, 5'b00010, 0, "t3b_b4");

      // 4: reset mid-pattern beats in=1
      step(1, 0, 5'b00001, 0, "t4_reset");
      step(0, 1, 5'b00010, 0, "t4_b1");
      step(0, 0, 5'b00100, 0, "t4_b2");
      step(0, 0, 5'b01000, 0, "t4_b3");
      step(1, 1, 5'b00001, 0, "t4_mid_reset");
      step(0, 1, 5'b00010, 0, "t4_resume");

      // 5: reset on the edge after detection
      step(1, 0, 5'b00001, 0, "t5_reset");
      step(0, 1, 5'b00010, 0, "t5_b1");
      step(0, 0, 5'b00100, 0, "t5_b2");
      step(0, 0, 5'b01000, 0, "t5_b3");
      step(0, 1, 5'b10000, 1, "t5_detect");
      step(1, 0, 5'b00001, 0, "t5_reset_in_s1001");

      // 6: eight 1s then eight 0s
      step(1, 0, 5'b00001, 0, "t6_reset");
      for (int i = 0; i < 8; i++) step(0, 1, 5'b00010, 0, $sformatf("t6_one%0d", i));
      step(0, 0, 5'b00100, 0, "t6_zero0");
      step(0, 0, 5'b01000, 0, "t6_zero1");
      for (int i = 2; i < 8; i++) step(0, 0, 5'b00001, 0, $sformatf("t6_zero%0d", i));

      // Bounded drain of the scoreboard
      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
